// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITERS);

    // Absolute value for two's-complement operands; unsigned operands pass through.
    function automatic logic [31:0] abs_mag(input logic [31:0] x, input logic sgn);
        abs_mag = (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// 32-bit two-level carry-lookahead adder: 4-bit lookahead groups, group carries chained.
// Latency: combinational.
// Backpressure: none.
module carry_lookahead_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [8:0]  gc;

    // Bit generate/propagate, in-group lookahead carries and group carry chain.
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        gc    = '0;
        gc[0] = cin;
        for (int i = 0; i < 8; i++) begin
            int  b0;
            logic grp_g;
            logic grp_p;
            b0 = 4 * i;
            c[b0]     = gc[i];
            c[b0 + 1] = g[b0] | (p[b0] & gc[i]);
            c[b0 + 2] = g[b0 + 1] | (p[b0 + 1] & g[b0]) | (p[b0 + 1] & p[b0] & gc[i]);
            c[b0 + 3] = g[b0 + 2] | (p[b0 + 2] & g[b0 + 1]) | (p[b0 + 2] & p[b0 + 1] & g[b0])
                      | (p[b0 + 2] & p[b0 + 1] & p[b0] & gc[i]);
            grp_g = g[b0 + 3] | (p[b0 + 3] & g[b0 + 2]) | (p[b0 + 3] & p[b0 + 2] & g[b0 + 1])
                  | (p[b0 + 3] & p[b0 + 2] & p[b0 + 1] & g[b0]);
            grp_p = &p[b0 +: 4];
            gc[i + 1] = grp_g | (grp_p & gc[i]);
        end
        sum  = p ^ c;
        cout = gc[8];
    end

endmodule

// File: rtl/iterative_divider.sv
// Restoring radix-2 32-bit divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Latency: result valid 34 cycles after accept (32 CALC + FIX), 1 cycle for divide-by-zero.
// Backpressure: in_ready only when idle; result held in DONE until out_ready.
module iterative_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = DIV_ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    input  logic             want_rem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    div_state_t           state;
    div_state_t           state_nxt;
    logic [DIV_CNT_W-1:0] count;
    logic [31:0]          rem_q;
    logic [31:0]          quo_q;
    logic [31:0]          dvs_q;
    logic                 neg_q;
    logic                 neg_r;
    logic                 want_rem_q;

    logic                 accept;
    logic [32:0]          shifted;
    logic [31:0]          sel;
    logic                 neg_sel;
    logic [31:0]          cla_a;
    logic [31:0]          cla_b;
    logic [31:0]          cla_sum;
    logic                 cla_cout;
    logic                 ok;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;

    assign shifted = {rem_q, quo_q[31]};
    assign sel     = want_rem_q ? rem_q : quo_q;
    assign neg_sel = want_rem_q ? neg_r : neg_q;
    assign ok      = shifted[32] | cla_cout;

    // Share the adder: trial subtraction in CALC, negation of the selected result in FIX.
    always_comb begin
        cla_a = shifted[31:0];
        cla_b = ~dvs_q;
        if (state == FIX) begin
            cla_a = '0;
            cla_b = ~sel;
        end
    end

    carry_lookahead_adder u_cla (
        .a    (cla_a),
        .b    (cla_b),
        .cin  (1'b1),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (divisor == '0) ? DONE : CALC;
            CALC: if (count == DIV_CNT_W'(ITERS - 1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, one restoring step per CALC cycle, sign fix-up into result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            want_rem_q <= 1'b0;
            result     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    want_rem_q <= want_rem;
                    neg_q      <= is_signed & (dividend[31] ^ divisor[31]);
                    neg_r      <= is_signed & dividend[31];
                    rem_q      <= '0;
                    quo_q      <= abs_mag(dividend, is_signed);
                    dvs_q      <= abs_mag(divisor, is_signed);
                    count      <= '0;
                    // Divide-by-zero skips iteration; remainder is the raw dividend.
                    if (divisor == '0) result <= want_rem ? dividend : '1;
                end
                CALC: begin
                    rem_q <= ok ? cla_sum : shifted[31:0];
                    quo_q <= {quo_q[30:0], ok};
                    count <= count + 1'b1;
                end
                FIX: result <= neg_sel ? cla_sum : sel;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed self-checking bench for iterative_divider.
// Latency: checks 34-cycle normal and 1-cycle divide-by-zero result timing.
// Backpressure: holds out_ready low in DONE and checks result/in_ready stability.
module tb_iterative_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        is_signed = 1'b0;
    logic        want_rem = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    iterative_divider dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .want_rem  (want_rem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Counts edges from the accept edge (inclusive) until out_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_after_hs"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic r, input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        want_rem  = r;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, result, exp);
        handshake(tag);
    endtask

    initial begin
        int lat;
        logic [31:0] held;

        // Reset state
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Unsigned basics
        op("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 34);
        op("remu_100_7", 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 34);

        // Signed truncation and remainder sign
        op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 34);
        op("rem_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 34);
        op("rem_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'd1, 34);

        // Divide by zero
        op("divu_5_0", 32'd5, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1);
        op("remu_5_0", 32'd5, 32'd0, 1'b0, 1'b1, 32'd5, 1);
        op("rem_m7_0", 32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFF9, 1);

        // Signed overflow and unsigned extreme
        op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 34);
        op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 34);
        op("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 34);

        // Backpressure with next request already pending
        @(negedge clk);
        dividend  = 32'd100;
        divisor   = 32'd7;
        is_signed = 1'b0;
        want_rem  = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_lat", lat, 34);
        check("bp_res", result, 32'd14);
        held = result;
        dividend = 32'd9;
        divisor  = 32'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_res", result, held);
            check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("b2b_idle", {31'd0, in_ready}, 32'd1);
        check("b2b_not_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_accepted", {31'd0, busy}, 32'd1);
        wait_valid(lat);
        check("b2b_lat", lat, 34);
        check("b2b_res", result, 32'd3);
        handshake("b2b");

        // Reset in the middle of CALC
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        op("after_rst_9_3", 32'd9, 32'd3, 1'b0, 1'b0, 32'd3, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
